// File: rtl/cache_line_pkg.sv
// cache_line_pkg: geometry constants and FSM encoding shared by the line-fill cache controller.
package cache_line_pkg;
  localparam int DATA_W     = 32;
  localparam int SRAM_DW    = 64;
  localparam int SRAM_AW    = 19;
  localparam int LINE_WORDS = 4;
  localparam int CNT_W      = 16;
  localparam int LINE_W     = LINE_WORDS * DATA_W;
  localparam int BEATS      = LINE_W / SRAM_DW;
  localparam int BEAT_W     = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WORD_OFF_W = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  localparam int LINE_OFF_W = $clog2(LINE_W / 8);
  localparam int WORD_SH    = $clog2(DATA_W / 8);
  localparam int BEAT_SH    = $clog2(SRAM_DW / 8);
  typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_e;
endpackage

// File: rtl/cache_line_ctrl_if.sv
// cache_line_ctrl_if: MEM-stage, SRAM and cache-array signals of the line-fill controller.
interface cache_line_ctrl_if;
  import cache_line_pkg::*;
  logic [31:0]         addr;
  logic [DATA_W-1:0]   wdata;
  logic                mem_r_en;
  logic                mem_w_en;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic [SRAM_AW-1:0]  sram_address;
  logic [DATA_W-1:0]   sram_wdata;
  logic                sram_read;
  logic                sram_write;
  logic [SRAM_DW-1:0]  sram_rdata;
  logic                sram_ready;
  logic                hit;
  logic [DATA_W-1:0]   cache_rdata;
  logic                cache_r_en;
  logic                cache_w_en;
  logic                cache_invalidate;
  logic [LINE_W-1:0]   cache_fill_data;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    miss_cnt;
  modport master (
    output addr, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready, hit, cache_rdata,
    input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write,
           cache_r_en, cache_w_en, cache_invalidate, cache_fill_data, hit_cnt, miss_cnt
  );
  modport slave (
    input  addr, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready, hit, cache_rdata,
    output rdata, ready, sram_address, sram_wdata, sram_read, sram_write,
           cache_r_en, cache_w_en, cache_invalidate, cache_fill_data, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_line_assembler.sv
// cache_line_assembler: collects SRAM beats into a cache line and selects the requested word.
module cache_line_assembler
  import cache_line_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [SRAM_DW-1:0]    beat_i,
  input  logic [WORD_OFF_W-1:0] sel_i,
  output logic [LINE_W-1:0]     line_o,
  output logic [BEAT_W-1:0]     beat_cnt_o,
  output logic                  last_o,
  output logic [DATA_W-1:0]     word_o
);
  logic [BEATS-1:0][SRAM_DW-1:0]     line_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0] words;
  logic [BEAT_W-1:0]                 beat_cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      line_q     <= '0;
      beat_cnt_q <= '0;
    end else if (clr_i) begin
      beat_cnt_q <= '0;
    end else if (we_i) begin
      line_q[beat_cnt_q] <= beat_i;
      beat_cnt_q         <= last_o ? '0 : beat_cnt_q + 1'b1;
    end
  assign last_o     = beat_cnt_q == BEAT_W'(BEATS - 1);
  assign beat_cnt_o = beat_cnt_q;
  assign line_o     = line_q;
  assign words      = line_q;
  assign word_o     = words[sel_i];
endmodule

// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl: write-through, no-write-allocate line-fill controller with hit/miss counters.
// Define WRITE_BUF_EN for a one-entry posted write buffer; otherwise stores block in WRITE.
module cache_line_ctrl
  import cache_line_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  cache_line_ctrl_if.slave bus
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;
  logic               fill_start, beat_we, last, hit_inc, miss_inc, wb_block;
  logic               ready, inval, cwen;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [LINE_W-1:0]  line;
  logic [DATA_W-1:0]  word;
  logic [SRAM_AW-1:0] fill_addr;
  logic               unused_ok;
  assign fill_addr = {bus.addr[SRAM_AW-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}} + (SRAM_AW'(beat_cnt) << BEAT_SH);
  assign beat_we   = state_q == FILL && bus.sram_ready;
  assign unused_ok = ^bus.addr[31:SRAM_AW];
  cache_line_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (fill_start),
    .we_i       (beat_we),
    .beat_i     (bus.sram_rdata),
    .sel_i      (bus.addr[WORD_SH +: WORD_OFF_W]),
    .line_o     (line),
    .beat_cnt_o (beat_cnt),
    .last_o     (last),
    .word_o     (word)
  );
`ifdef WRITE_BUF_EN
  logic [SRAM_AW-1:0] wb_addr_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic               wb_vld_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (inval) begin
      wb_vld_q  <= 1'b1;
      wb_addr_q <= bus.addr[SRAM_AW-1:0];
      wb_data_q <= bus.wdata;
    end else if (wb_vld_q && bus.sram_ready) begin
      wb_vld_q <= 1'b0;
    end
  assign wb_block         = wb_vld_q;
  assign bus.sram_write   = wb_vld_q;
  assign bus.sram_wdata   = wb_data_q;
  assign bus.sram_address = state_q == FILL ? fill_addr : wb_addr_q;
`else
  assign wb_block         = 1'b0;
  assign bus.sram_write   = state_q == WRITE;
  assign bus.sram_wdata   = bus.wdata;
  assign bus.sram_address = state_q == FILL ? fill_addr : bus.addr[SRAM_AW-1:0];
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    inval      = 1'b0;
    cwen       = 1'b0;
    fill_start = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    unique case (state_q)
      IDLE:
        if (bus.mem_r_en) begin
          if (bus.hit) begin
            ready   = 1'b1;
            hit_inc = 1'b1;
          end else if (!wb_block) begin
            miss_inc   = 1'b1;
            fill_start = 1'b1;
            state_d    = FILL;
          end
        end else if (bus.mem_w_en) begin
`ifdef WRITE_BUF_EN
          ready = !wb_block;
          inval = !wb_block;
`else
          inval   = 1'b1;
          state_d = WRITE;
`endif
        end else begin
          ready = 1'b1;
        end
      FILL:  if (beat_we && last) state_d = RESP;
      RESP: begin
        cwen    = 1'b1;
        ready   = 1'b1;
        state_d = IDLE;
      end
      WRITE: begin
        ready = bus.sram_ready;
        if (bus.sram_ready) state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && !(&hit_cnt_q))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_inc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  assign bus.ready            = ready;
  assign bus.rdata            = state_q == RESP ? word : bus.cache_rdata;
  assign bus.sram_read        = state_q == FILL;
  assign bus.cache_r_en       = state_q == IDLE && bus.mem_r_en;
  assign bus.cache_w_en       = cwen;
  assign bus.cache_invalidate = inval;
  assign bus.cache_fill_data  = line;
  assign bus.hit_cnt          = hit_cnt_q;
  assign bus.miss_cnt         = miss_cnt_q;
endmodule
